code_lock_ctrl: RTL and testbench

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

---
 rtl/code_lock_ctrl.sv | 149 ++++++++++++++
 tb/tb_code_lock_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// ============================================================================
// Module  : code_lock_ctrl
// Brief   : Three-digit card-and-code door lock with retry limit and lockout.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module code_lock_ctrl #(
    parameter logic [3:0] CODE_A      = 4'd1,
    parameter logic [3:0] CODE_B      = 4'd3,
    parameter logic [3:0] CODE_C      = 4'd7,
    parameter int         MAX_TRIES   = 3,
    parameter int         OPEN_CYCLES = 8,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       cartao,
    input  logic [3:0] codigo,
    input  logic       enter,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] tentativas,
    output logic [1:0] stage
);

    localparam int MAX_CYCLES = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIG_A   = 3'd1,
        DIG_B   = 3'd2,
        DIG_C   = 3'd3,
        OPEN    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [2:0]    tries, tries_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          enter_q;
    logic          enter_ev;
    logic [3:0]    digit_exp;
    logic [2:0]    tries_inc;

    assign enter_ev  = enter & ~enter_q;
    assign tries_inc = tries + 3'd1;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tries   <= '0;
            cnt     <= '0;
            enter_q <= 1'b0;
        end else begin
            state   <= state_n;
            tries   <= tries_n;
            cnt     <= cnt_n;
            enter_q <= enter;
        end
    end

    always_comb begin
        digit_exp = CODE_A;
        case (state)
            DIG_B:   digit_exp = CODE_B;
            DIG_C:   digit_exp = CODE_C;
            default: digit_exp = CODE_A;
        endcase
    end

    always_comb begin
        state_n = state;
        tries_n = tries;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (cartao)
                    state_n = DIG_A;
            end
            DIG_A, DIG_B, DIG_C: begin
                // Card removal wins over a coincident enter event.
                if (!cartao) begin
                    state_n = IDLE;
                end else if (enter_ev) begin
                    if (codigo == digit_exp) begin
                        if (state == DIG_C) begin
                            state_n = OPEN;
                            cnt_n   = CW'(OPEN_CYCLES);
                            tries_n = '0;
                        end else if (state == DIG_A) begin
                            state_n = DIG_B;
                        end else begin
                            state_n = DIG_C;
                        end
                    end else begin
                        tries_n = tries_inc;
                        if (tries_inc == 3'(MAX_TRIES)) begin
                            state_n = LOCKOUT;
                            cnt_n   = CW'(LOCK_CYCLES);
                        end else begin
                            state_n = DIG_A;
                        end
                    end
                end
            end
            OPEN: begin
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            LOCKOUT: begin
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    tries_n = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                tries_n = '0;
            end
        endcase
    end

    assign unlock     = (state == OPEN);
    assign alarm      = (state == LOCKOUT);
    assign tentativas = tries;

    always_comb begin
        stage = 2'd0;
        case (state)
            DIG_B:   stage = 2'd1;
            DIG_C:   stage = 2'd2;
            OPEN:    stage = 2'd3;
            default: stage = 2'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
// ============================================================================
// Module  : tb_code_lock_ctrl
// Brief   : Directed and randomized checks of code_lock_ctrl against a model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_code_lock_ctrl;

    localparam logic [3:0] CODE_A      = 4'd1;
    localparam logic [3:0] CODE_B      = 4'd3;
    localparam logic [3:0] CODE_C      = 4'd7;
    localparam int         MAX_TRIES   = 3;
    localparam int         OPEN_CYCLES = 8;
    localparam int         LOCK_CYCLES = 16;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       cartao = 1'b0;
    logic [3:0] codigo = 4'd0;
    logic       enter = 1'b0;
    logic       unlock;
    logic       alarm;
    logic [2:0] tentativas;
    logic [1:0] stage;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    code_lock_ctrl #(
        .CODE_A(CODE_A), .CODE_B(CODE_B), .CODE_C(CODE_C),
        .MAX_TRIES(MAX_TRIES), .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk_2(clk_2),
        .reset(reset),
        .cartao(cartao),
        .codigo(codigo),
        .enter(enter),
        .unlock(unlock),
        .alarm(alarm),
        .tentativas(tentativas),
        .stage(stage)
    );

    always #5 clk_2 = ~clk_2;

    // Reference model: session flag, digits matched, remaining open/alarm time.
    logic [3:0] codes [3];
    int m_tries, m_matched, m_open, m_lock;
    bit m_sess, m_prev, m_ev;

    initial begin
        codes[0] = CODE_A;
        codes[1] = CODE_B;
        codes[2] = CODE_C;
    end

    always @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            m_tries = 0; m_matched = 0; m_open = 0; m_lock = 0;
            m_sess = 0; m_prev = 0;
        end else begin
            m_ev   = enter && !m_prev;
            m_prev = enter;
            if (m_open > 0) begin
                m_open--;
            end else if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_tries = 0;
            end else if (!m_sess) begin
                if (cartao) begin m_sess = 1; m_matched = 0; end
            end else if (!cartao) begin
                m_sess = 0; m_matched = 0;
            end else if (m_ev) begin
                if (codigo == codes[m_matched]) begin
                    m_matched++;
                    if (m_matched == 3) begin
                        m_open = OPEN_CYCLES; m_tries = 0; m_matched = 0; m_sess = 0;
                    end
                end else begin
                    m_tries++;
                    m_matched = 0;
                    if (m_tries == MAX_TRIES) begin
                        m_lock = LOCK_CYCLES; m_sess = 0;
                    end
                end
            end
        end
    end

    function automatic int exp_stage();
        if (m_open > 0) return 3;
        if (m_lock > 0) return 0;
        if (m_sess) return m_matched;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_2) begin
        if (chk_en) begin
            check("model_unlock", 32'(unlock),     32'(m_open > 0));
            check("model_alarm",  32'(alarm),      32'(m_lock > 0));
            check("model_tries",  32'(tentativas), 32'(m_tries));
            check("model_stage",  32'(stage),      32'(exp_stage()));
        end
    end

    task automatic tick();
        @(posedge clk_2);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; cartao = 1'b0; enter = 1'b0; codigo = 4'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] d);
        codigo = d; enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("reset_unlock", 32'(unlock), 0);
        check("reset_alarm",  32'(alarm), 0);
        check("reset_tries",  32'(tentativas), 0);
        check("reset_stage",  32'(stage), 0);

        // Correct code opens the door for OPEN_CYCLES clocks.
        cartao = 1'b1; tick();
        pulse(4'd1); check("ok_stage1", 32'(stage), 1); check("model_pin_stage1", 32'(exp_stage()), 1);
        tick();
        pulse(4'd3); check("ok_stage2", 32'(stage), 2);
        tick();
        pulse(4'd7); check("ok_stage3", 32'(stage), 3);
        check("ok_unlock", 32'(unlock), 1); check("ok_tries0", 32'(tentativas), 0);
        repeat (OPEN_CYCLES - 1) tick();
        check("ok_unlock_last", 32'(unlock), 1);
        tick();
        check("ok_unlock_end", 32'(unlock), 0); check("ok_stage_idle", 32'(stage), 0);

        // Three wrong entries trigger a LOCK_CYCLES lockout.
        do_reset();
        cartao = 1'b1; tick();
        pulse(4'd2); check("wrong_tries1", 32'(tentativas), 1); tick();
        pulse(4'd2); check("wrong_tries2", 32'(tentativas), 2); tick();
        pulse(4'd2); check("wrong_tries3", 32'(tentativas), 3);
        check("lock_alarm", 32'(alarm), 1); check("model_pin_lock", 32'(m_lock), LOCK_CYCLES);
        repeat (LOCK_CYCLES - 1) tick();
        check("lock_alarm_last", 32'(alarm), 1);
        tick();
        check("lock_alarm_end", 32'(alarm), 0); check("lock_tries_clr", 32'(tentativas), 0);

        // Card removal beats a coincident enter.
        do_reset();
        cartao = 1'b1; tick();
        pulse(4'd2); tick();
        pulse(4'd1); check("rm_stage1", 32'(stage), 1); tick();
        cartao = 1'b0;
        pulse(4'd3);
        check("rm_stage0", 32'(stage), 0); check("rm_tries_kept", 32'(tentativas), 1);

        // A held enter counts once.
        do_reset();
        cartao = 1'b1; tick();
        codigo = 4'd5; enter = 1'b1;
        repeat (10) tick();
        enter = 1'b0;
        check("held_once", 32'(tentativas), 1);

        // Wrong third digit returns to the first digit.
        do_reset();
        cartao = 1'b1; tick();
        pulse(4'd1); tick(); pulse(4'd3); tick(); pulse(4'd4);
        check("dc_tries", 32'(tentativas), 1); check("dc_stage", 32'(stage), 0);
        tick();
        pulse(4'd1); check("dc_back_at_a", 32'(stage), 1);

        // Reset between edges in the middle of a lockout.
        do_reset();
        cartao = 1'b1; tick();
        repeat (3) begin pulse(4'd9); tick(); end
        repeat (4) tick();
        check("mid_lock_alarm", 32'(alarm), 1);
        #1 reset = 1'b1;
        #1;
        check("async_alarm", 32'(alarm), 0);
        check("async_tries", 32'(tentativas), 0);
        check("async_stage", 32'(stage), 0);
        tick();
        reset = 1'b0;

        // Randomized traffic biased toward the correct next digit.
        for (int i = 0; i < 4000; i++) begin
            cartao = ($urandom_range(0, 19) != 0);
            enter  = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 1) == 1)
                codigo = codes[m_matched % 3];
            else
                codigo = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 599) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
